// File: rtl/conv_input_feeder.sv
// Conv input feeder: for each kernel/channel pair, reads the 2-word kernel and then every fmap window row,
// and delivers registered 8-lane beats to the conv engine.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for in_start; no memory reads
// KLOAD | kernel word reads h=0,1 for the current (k,c) pair
// FEED  | fmap reads, window rows r, column pairs j
// DRAIN | 2 cycles while the read pipeline empties; then IDLE
module conv_input_feeder #(
  parameter int LEN_IN    = 8,
  parameter int FMAP_ROWS = 61,
  parameter int COL_PAIRS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_start,
  input  logic [2:0]        in_cfg_ci,
  input  logic [2:0]        in_cfg_co,
  output logic              mem_k_rd_en,
  output logic [10:0]       mem_k_addr,
  input  logic [63:0]       mem_k_rdata,
  output logic              mem_f_rd_en,
  output logic [15:0]       mem_f_addr0,
  output logic [15:0]       mem_f_addr1,
  output logic [15:0]       mem_f_addr2,
  output logic [15:0]       mem_f_addr3,
  input  logic [15:0]       mem_f_rdata0,
  input  logic [15:0]       mem_f_rdata1,
  input  logic [15:0]       mem_f_rdata2,
  input  logic [15:0]       mem_f_rdata3,
  output logic [LEN_IN-1:0] out_data0,
  output logic [LEN_IN-1:0] out_data1,
  output logic [LEN_IN-1:0] out_data2,
  output logic [LEN_IN-1:0] out_data3,
  output logic [LEN_IN-1:0] out_data4,
  output logic [LEN_IN-1:0] out_data5,
  output logic [LEN_IN-1:0] out_data6,
  output logic [LEN_IN-1:0] out_data7,
  output logic              out_valid,
  output logic              out_kphase,
  output logic              out_busy,
  output logic              out_done
);

  localparam int RW = (FMAP_ROWS > 1) ? $clog2(FMAP_ROWS) : 1;
  localparam int CW = (COL_PAIRS > 1) ? $clog2(COL_PAIRS) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(FMAP_ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COL_PAIRS - 1);

  typedef enum logic [1:0] {IDLE, KLOAD, FEED, DRAIN} state_t;
  state_t state, state_nxt;

  logic [4:0]    k_cnt, c_cnt, nci_m1, nco_m1;
  logic          h_cnt, d_cnt;
  logic [RW-1:0] r_cnt;
  logic [CW-1:0] j_cnt;
  logic          start_ok, feed_last, run_last;
  logic [9:0]    pair_idx;
  logic [3:0][15:0] f_addr;
  logic [3:0][15:0] f_rdata;
  logic          v1, kp1, last1, last2;
  logic [7:0][LEN_IN-1:0] lane_q;

  function automatic logic [4:0] count_m1(input logic [2:0] code);
    case (code)
      3'd0:    return 5'd7;
      3'd1:    return 5'd15;
      3'd2:    return 5'd23;
      default: return 5'd31;
    endcase
  endfunction

  // A start arriving in the completion cycle is dropped, not queued.
  assign start_ok  = in_start && !out_done;
  assign feed_last = (r_cnt == ROW_LAST) && (j_cnt == COL_LAST);
  assign run_last  = (k_cnt == nco_m1) && (c_cnt == nci_m1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = KLOAD;
      KLOAD:   if (h_cnt) state_nxt = FEED;
      FEED:    if (feed_last) state_nxt = run_last ? DRAIN : KLOAD;
      DRAIN:   if (d_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_cnt  <= '0;
      c_cnt  <= '0;
      h_cnt  <= 1'b0;
      r_cnt  <= '0;
      j_cnt  <= '0;
      d_cnt  <= 1'b0;
      nci_m1 <= '0;
      nco_m1 <= '0;
    end else begin
      case (state)
        IDLE: if (start_ok) begin
          nci_m1 <= count_m1(in_cfg_ci);
          nco_m1 <= count_m1(in_cfg_co);
          k_cnt  <= '0;
          c_cnt  <= '0;
          h_cnt  <= 1'b0;
          r_cnt  <= '0;
          j_cnt  <= '0;
          d_cnt  <= 1'b0;
        end
        KLOAD: h_cnt <= ~h_cnt;
        FEED: begin
          if (j_cnt == COL_LAST) begin
            j_cnt <= '0;
            r_cnt <= (r_cnt == ROW_LAST) ? '0 : r_cnt + RW'(1);
          end else begin
            j_cnt <= j_cnt + CW'(1);
          end
          if (feed_last) begin
            if (c_cnt == nci_m1) begin
              c_cnt <= '0;
              k_cnt <= k_cnt + 5'd1;
            end else begin
              c_cnt <= c_cnt + 5'd1;
            end
          end
        end
        DRAIN: d_cnt <= ~d_cnt;
        default: ;
      endcase
    end
  end

  // Fmap row stride is fixed at 32 words and channel stride at 2048 words.
  always_comb begin
    pair_idx    = 10'(k_cnt) * (10'(nci_m1) + 10'd1) + 10'(c_cnt);
    mem_k_rd_en = (state == KLOAD);
    mem_k_addr  = mem_k_rd_en ? {pair_idx, h_cnt} : '0;
    mem_f_rd_en = (state == FEED);
    for (int n = 0; n < 4; n++) begin
      f_addr[n] = mem_f_rd_en ?
                  ({c_cnt, 11'd0} + ((16'(r_cnt) + 16'(n)) << 5) + 16'(j_cnt)) : '0;
    end
  end

  assign mem_f_addr0 = f_addr[0];
  assign mem_f_addr1 = f_addr[1];
  assign mem_f_addr2 = f_addr[2];
  assign mem_f_addr3 = f_addr[3];
  assign f_rdata     = {mem_f_rdata3, mem_f_rdata2, mem_f_rdata1, mem_f_rdata0};

  // v1/kp1 track the cycle in which memory data is valid; lanes capture on the following edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1         <= 1'b0;
      kp1        <= 1'b0;
      last1      <= 1'b0;
      last2      <= 1'b0;
      out_valid  <= 1'b0;
      out_kphase <= 1'b0;
      out_done   <= 1'b0;
      lane_q     <= '0;
    end else begin
      v1         <= mem_k_rd_en | mem_f_rd_en;
      kp1        <= mem_k_rd_en;
      last1      <= mem_f_rd_en && feed_last && run_last;
      last2      <= last1;
      out_done   <= last2;
      out_valid  <= v1;
      out_kphase <= v1 && kp1;
      if (v1) begin
        for (int i = 0; i < 8; i++) begin
          lane_q[i] <= kp1 ? LEN_IN'(mem_k_rdata[8*i +: 8])
                           : LEN_IN'(f_rdata[i % 4][8*(i / 4) +: 8]);
        end
      end
    end
  end

  assign out_busy  = (state != IDLE) || out_done;
  assign out_data0 = lane_q[0];
  assign out_data1 = lane_q[1];
  assign out_data2 = lane_q[2];
  assign out_data3 = lane_q[3];
  assign out_data4 = lane_q[4];
  assign out_data5 = lane_q[5];
  assign out_data6 = lane_q[6];
  assign out_data7 = lane_q[7];

endmodule

// File: tb/tb_conv_input_feeder.sv
// Bench for conv_input_feeder: memory model, loop-order beat model built from plain arithmetic,
// and a per-cycle compare of read addresses and output beats.
module tb_conv_input_feeder;
  localparam int ROWS = 6;
  localparam int COLS = 4;
  localparam int PB   = 2 + ROWS * COLS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic [2:0]  in_cfg_ci = 3'd0, in_cfg_co = 3'd0;
  logic        mem_k_rd_en, mem_f_rd_en;
  logic [10:0] mem_k_addr;
  logic [63:0] mem_k_rdata = '0;
  logic [15:0] mem_f_addr0, mem_f_addr1, mem_f_addr2, mem_f_addr3;
  logic [15:0] mem_f_rdata0 = '0, mem_f_rdata1 = '0, mem_f_rdata2 = '0, mem_f_rdata3 = '0;
  logic [7:0]  out_data0, out_data1, out_data2, out_data3;
  logic [7:0]  out_data4, out_data5, out_data6, out_data7;
  logic        out_valid, out_kphase, out_busy, out_done;

  conv_input_feeder #(.LEN_IN(8), .FMAP_ROWS(ROWS), .COL_PAIRS(COLS)) dut (
    .clk(clk), .rst_n(rst_n), .in_start(in_start),
    .in_cfg_ci(in_cfg_ci), .in_cfg_co(in_cfg_co),
    .mem_k_rd_en(mem_k_rd_en), .mem_k_addr(mem_k_addr), .mem_k_rdata(mem_k_rdata),
    .mem_f_rd_en(mem_f_rd_en),
    .mem_f_addr0(mem_f_addr0), .mem_f_addr1(mem_f_addr1),
    .mem_f_addr2(mem_f_addr2), .mem_f_addr3(mem_f_addr3),
    .mem_f_rdata0(mem_f_rdata0), .mem_f_rdata1(mem_f_rdata1),
    .mem_f_rdata2(mem_f_rdata2), .mem_f_rdata3(mem_f_rdata3),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_data4(out_data4), .out_data5(out_data5), .out_data6(out_data6), .out_data7(out_data7),
    .out_valid(out_valid), .out_kphase(out_kphase), .out_busy(out_busy), .out_done(out_done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory contents. Mode 0: kernel word w = {8{w[7:0]}}, pixel = column mod 64.
  // Mode 1: per-byte hashes so lane or port swaps show up.
  bit fmap_mode = 1'b0;

  function automatic logic [63:0] kword(input logic [10:0] w, input bit mode);
    logic [63:0] r;
    int wi;
    wi = int'(w);
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = mode ? 8'(wi * 7 + (wi >> 8) * 13 + i * 29 + 3) : w[7:0];
    return r;
  endfunction

  function automatic logic [15:0] fword(input logic [15:0] a, input int port, input bit mode);
    int ai, j;
    ai = int'(a);
    j  = ai % 32;
    if (!mode) return {8'((2 * j + 1) % 64), 8'((2 * j) % 64)};
    return {8'(ai * 5 + (ai >> 8) * 11 + port * 41 + 1), 8'(ai * 3 + (ai >> 8) * 7 + port * 17)};
  endfunction

  always @(posedge clk) begin
    mem_k_rdata  <= mem_k_rd_en ? kword(mem_k_addr, fmap_mode) : 64'hDEADBEEFCAFEF00D;
    mem_f_rdata0 <= mem_f_rd_en ? fword(mem_f_addr0, 0, fmap_mode) : 16'hBEEF;
    mem_f_rdata1 <= mem_f_rd_en ? fword(mem_f_addr1, 1, fmap_mode) : 16'hBEEF;
    mem_f_rdata2 <= mem_f_rd_en ? fword(mem_f_addr2, 2, fmap_mode) : 16'hBEEF;
    mem_f_rdata3 <= mem_f_rd_en ? fword(mem_f_addr3, 3, fmap_mode) : 16'hBEEF;
  end

  typedef struct packed {
    logic             kp;
    logic [10:0]      ka;
    logic [3:0][15:0] fa;
  } addr_t;

  typedef struct packed {
    logic            kp;
    logic [7:0][7:0] d;
  } beat_t;

  addr_t aq[$];
  beat_t bq[$];
  int    aidx, didx, kp_beats;

  task automatic build_model(input int nci, input int nco);
    addr_t a;
    beat_t b;
    logic [63:0] w;
    logic [15:0] f;
    aq.delete();
    bq.delete();
    aidx = 0;
    didx = 0;
    kp_beats = 0;
    for (int k = 0; k < nco; k++)
      for (int c = 0; c < nci; c++) begin
        for (int h = 0; h < 2; h++) begin
          a.kp = 1'b1;
          a.ka = 11'((k * nci + c) * 2 + h);
          a.fa = '0;
          aq.push_back(a);
          w = kword(a.ka, fmap_mode);
          b.kp = 1'b1;
          for (int i = 0; i < 8; i++) b.d[i] = w[8*i +: 8];
          bq.push_back(b);
        end
        for (int r = 0; r < ROWS; r++)
          for (int j = 0; j < COLS; j++) begin
            a.kp = 1'b0;
            a.ka = '0;
            for (int n = 0; n < 4; n++) a.fa[n] = 16'(c * 2048 + (r + n) * 32 + j);
            aq.push_back(a);
            b.kp = 1'b0;
            for (int n = 0; n < 4; n++) begin
              f = fword(a.fa[n], n, fmap_mode);
              b.d[n]     = f[7:0];
              b.d[n + 4] = f[15:8];
            end
            bq.push_back(b);
          end
      end
  endtask

  bit               chk_en = 1'b0;
  logic [7:0][7:0]  last_exp = '0;
  logic [7:0][7:0]  dut_d;
  logic [3:0][15:0] dut_fa;
  addr_t            ea;
  beat_t            eb;
  logic [10:0]      pin_ka0, pin_ka260, pin_ka261;
  logic [15:0]      pin_fa0_103, pin_fa3_103;
  logic [63:0]      pin_d103;

  assign dut_d  = {out_data7, out_data6, out_data5, out_data4,
                   out_data3, out_data2, out_data1, out_data0};
  assign dut_fa = {mem_f_addr3, mem_f_addr2, mem_f_addr1, mem_f_addr0};

  always @(negedge clk) begin
    if (chk_en) begin
      if (mem_k_rd_en || mem_f_rd_en) begin
        if (aq.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL addr_overrun: read at k_addr %0h f_addr0 %0h, model expects no read",
                   mem_k_addr, mem_f_addr0);
        end else begin
          ea = aq.pop_front();
          chk("rd_en", 128'({mem_k_rd_en, mem_f_rd_en}), 128'({ea.kp, !ea.kp}));
          chk("k_addr", 128'(mem_k_addr), 128'(ea.ka));
          chk("f_addr", 128'(dut_fa), 128'(ea.fa));
          if (aidx == 0)   pin_ka0 = mem_k_addr;
          if (aidx == 260) pin_ka260 = mem_k_addr;
          if (aidx == 261) pin_ka261 = mem_k_addr;
          if (aidx == 103) begin
            pin_fa0_103 = mem_f_addr0;
            pin_fa3_103 = mem_f_addr3;
          end
          aidx++;
        end
      end else begin
        chk("idle_addr", 128'({mem_k_addr, dut_fa}), 128'(0));
      end
      if (out_valid) begin
        if (bq.size() == 0) begin
          tests_run++;
          fails++;
          $display("FAIL beat_overrun: beat %0h delivered, model expects none", dut_d);
        end else begin
          eb = bq.pop_front();
          chk("beat_kphase", 128'(out_kphase), 128'(eb.kp));
          chk("beat_data", 128'(dut_d), 128'(eb.d));
          last_exp = eb.d;
          if (out_kphase) kp_beats++;
          if (didx == 103) pin_d103 = dut_d;
          didx++;
        end
      end else begin
        chk("hold", 128'({out_kphase, dut_d}), 128'({1'b0, last_exp}));
      end
    end
  end

  task automatic chk_zero(input string name);
    chk({name, "_mem"}, 128'({mem_k_rd_en, mem_k_addr, mem_f_rd_en, dut_fa}), 128'(0));
    chk({name, "_out"}, 128'({out_valid, out_kphase, out_busy, out_done, dut_d}), 128'(0));
  endtask

  task automatic run_case(input logic [2:0] ci, input logic [2:0] co, input int nci, input int nco,
                          input int exp_beats, input bit mode, input bit disturb);
    int lat, beats;
    fmap_mode = mode;
    build_model(nci, nco);
    chk("model_size", 128'(bq.size()), 128'(exp_beats));
    chk_en = 1'b1;
    @(negedge clk);
    in_cfg_ci = ci;
    in_cfg_co = co;
    in_start  = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    chk("busy_after_start", 128'(out_busy), 128'(1));
    lat = 0;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_latency", 128'(lat), 128'(2));
    beats = 0;
    while (out_valid && beats <= exp_beats) begin
      beats++;
      if (disturb && beats == 50) begin
        in_start  = 1'b1;
        in_cfg_ci = 3'd0;
        in_cfg_co = 3'd3;
      end
      if (beats == 51) in_start = 1'b0;
      @(negedge clk);
    end
    chk("beat_count", 128'(beats), 128'(exp_beats));
    chk("done_pulse", 128'({out_done, out_busy, out_valid}), 128'(3'b110));
    if (disturb) in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    chk("done_end", 128'({out_done, out_busy, out_valid}), 128'(0));
    repeat (3) @(negedge clk);
    chk("no_restart", 128'({out_busy, mem_k_rd_en, mem_f_rd_en, out_valid}), 128'(0));
    chk("model_drained", 128'(aq.size() + bq.size()), 128'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 8x8 pairs, literal memory patterns
    run_case(3'd0, 3'd0, 8, 8, 1664, 1'b0, 1'b0);
    chk("pin_k_addr_k1c2_h0", 128'(pin_ka260), 128'(20));
    chk("pin_k_addr_k1c2_h1", 128'(pin_ka261), 128'(21));
    chk("pin_kphase_beats", 128'(kp_beats), 128'(128));
    chk("pin_f_addr0_c3r5j3", 128'(pin_fa0_103), 128'(6307));
    chk("pin_f_addr3_c3r5j3", 128'(pin_fa3_103), 128'(6403));
    chk("pin_data_c3r5j3", 128'(pin_d103), 128'(64'h0707070706060606));

    // code 5 means 32 channels; start and cfg changes during the run are ignored
    run_case(3'd5, 3'd0, 32, 8, 6656, 1'b1, 1'b1);

    // abort during FEED of pair (2,1): address cycle 17*26+7 is r=1, j=1
    fmap_mode = 1'b1;
    build_model(8, 8);
    chk_en = 1'b1;
    @(negedge clk);
    in_cfg_ci = 3'd0;
    in_cfg_co = 3'd0;
    in_start  = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    repeat (449) @(negedge clk);
    chk("abort_point", 128'({mem_f_rd_en, mem_f_addr0}), 128'({1'b1, 16'd2081}));
    chk_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_zero("abort_reset");
    @(negedge clk);
    chk_zero("abort_quiet");
    repeat (3) @(negedge clk);
    chk_zero("abort_quiet2");
    last_exp = '0;

    run_case(3'd0, 3'd0, 8, 8, 1664, 1'b1, 1'b0);
    chk("restart_first_k_addr", 128'(pin_ka0), 128'(0));

    // 24 channels x 16 kernels
    run_case(3'd2, 3'd1, 24, 16, 9984, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
